// File: rtl/ins_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ins_loader_pkg                                                       |
// | Shared CPU definitions: control-signal levels, loader FSM states and |
// | the byte-lane order used when assembling instruction words.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ins_loader_pkg;

   localparam logic C_CPU_HOLD = 1'b0;
   localparam logic C_CPU_RUN  = 1'b1;

   localparam int C_BYTES_PER_WORD = 4;
   // Lane receiving the first byte of a word; top lane means big-endian.
   localparam int C_FIRST_BYTE_LANE = C_BYTES_PER_WORD - 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ins_loader_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_packer                                                          |
// | Byte counter and shift register assembling 32-bit instruction words. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module byte_packer
   import ins_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        take,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        last_byte
);

   logic [1:0]  r_cnt;
   logic [31:0] r_word;

   generate
      if (C_FIRST_BYTE_LANE == C_BYTES_PER_WORD - 1) begin : g_big_endian
         assign word_next = {r_word[23:0], byte_in};
      end else begin : g_little_endian
         assign word_next = {byte_in, r_word[31:8]};
      end
   endgenerate

   // word_next already holds the complete word in the cycle the last byte lands.
   assign last_byte = take && (r_cnt == 2'(C_BYTES_PER_WORD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_word <= '0;
      end else if (clear) begin
         r_cnt  <= '0;
         r_word <= '0;
      end else if (take) begin
         r_cnt  <= r_cnt + 2'd1;
         r_word <= word_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ins_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ins_loader                                                           |
// | Streams program bytes into instruction memory, then releases the CPU.|
// | Optional end-of-load checksum byte: define INS_LOADER_CKSUM_EN.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ins_loader
   import ins_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic            Start,
   input  logic [ADDR_W:0] WordCount,
   input  logic [7:0]      ByteData,
   input  logic            ByteValid,
   output logic            ByteReady,
   output logic            MemWe,
   output logic [31:0]     MemAddr,
   output logic [31:0]     MemData,
   output logic            CpuRun,
   output logic            Busy,
   output logic            Err
);

   localparam logic [ADDR_W:0] C_MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] C_ONE       = {{ADDR_W{1'b0}}, 1'b1};
`ifdef INS_LOADER_CKSUM_EN
   localparam state_t C_END_STATE = S_CHECK;
`else
   localparam state_t C_END_STATE = S_DONE;
`endif

   state_t          r_state;
   state_t          w_next;
   logic [ADDR_W:0] r_count;
   logic [ADDR_W:0] r_idx;
   logic [ADDR_W:0] w_idx_inc;
   logic [ADDR_W:0] w_clamped;
   logic [31:0]     r_addr;
   logic [31:0]     r_data;
   logic [31:0]     w_word_next;
   logic            w_start_ok;
   logic            w_take;
   logic            w_last_byte;

   assign w_start_ok = Start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_take     = ByteValid && (r_state == S_RECV);
   assign w_clamped  = (WordCount > C_MAX_WORDS) ? C_MAX_WORDS : WordCount;
   assign w_idx_inc  = r_idx + C_ONE;
   assign MemAddr    = r_addr;
   assign MemData    = r_data;

   byte_packer u_packer (
      .clk       (CLK),
      .rst_n     (Reset),
      .clear     (w_start_ok),
      .take      (w_take),
      .byte_in   (ByteData),
      .word_next (w_word_next),
      .last_byte (w_last_byte)
   );

`ifdef INS_LOADER_CKSUM_EN
   logic [7:0] r_cksum;
   logic       r_err;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_cksum <= '0;
         r_err   <= 1'b0;
      end else if (w_start_ok) begin
         r_cksum <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_take) begin
            r_cksum <= r_cksum ^ ByteData;
         end
         if (r_state == S_CHECK && ByteValid && ByteData != r_cksum) begin
            r_err <= 1'b1;
         end
      end
   end

   assign Err = r_err;
`else
   assign Err = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      ByteReady = 1'b0;
      MemWe     = 1'b0;
      CpuRun    = C_CPU_HOLD;
      Busy      = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            CpuRun = (r_state == S_DONE) ? C_CPU_RUN : C_CPU_HOLD;
            if (w_start_ok) begin
               w_next = (w_clamped == '0) ? C_END_STATE : S_RECV;
            end
         end
         S_RECV: begin
            ByteReady = 1'b1;
            Busy      = 1'b1;
            if (w_last_byte) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            MemWe  = 1'b1;
            Busy   = 1'b1;
            w_next = (w_idx_inc == r_count) ? C_END_STATE : S_RECV;
         end
`ifdef INS_LOADER_CKSUM_EN
         S_CHECK: begin
            // The checksum byte uses the same valid/ready handshake as program bytes.
            ByteReady = 1'b1;
            Busy      = 1'b1;
            if (ByteValid) begin
               w_next = (ByteData == r_cksum) ? S_DONE : S_IDLE;
            end
         end
`endif
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_idx   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         if (w_start_ok) begin
            r_count <= w_clamped;
            r_idx   <= '0;
         end
         if (r_state == S_WRITE) begin
            r_idx <= w_idx_inc;
         end
         if (w_last_byte) begin
            r_addr <= 32'({r_idx[ADDR_W-1:0], 2'b00});
            r_data <= w_word_next;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/ins_loader.md
INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address width of instruction memory (capacity 2^ADDR_W words).
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port Reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Start  input  1  single-cycle request to begin a load.
REQ-005 SHALL have port WordCount  input  ADDR_W+1  number of 32-bit words to load, sampled on accepted Start.
REQ-006 SHALL have port ByteData  input  8  incoming program byte.
REQ-007 SHALL have port ByteValid  input  1  ByteData valid.
REQ-008 SHALL have port ByteReady  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port MemWe  output  1  instruction-memory write strobe.
REQ-010 SHALL have port MemAddr  output  32  byte address, word-aligned.
REQ-011 SHALL have port MemData  output  32  word to write.
REQ-012 SHALL have port CpuRun  output  1  high permits the CPU to leave reset.
REQ-013 SHALL have port Busy  output  1  load in progress.
REQ-014 SHALL have port Err  output  1  load failed.

Function
REQ-015 SHALL implement FSM states IDLE, RECV, WRITE, CHECK, DONE.
REQ-016 SHALL accept Start only in IDLE or DONE; Start in RECV/WRITE/CHECK is ignored.
REQ-017 On accepted Start: latch min(WordCount, 2^ADDR_W), clear word index, byte count, Err and CpuRun; go to RECV, or to CHECK/DONE next cycle if the count is 0.
REQ-018 ByteReady SHALL be high only in RECV; a byte transfers when ByteValid && ByteReady.
REQ-019 SHALL assemble bytes big-endian: first byte to [31:24], fourth to [7:0].
REQ-020 After the fourth transferred byte: enter WRITE; MemWe high exactly one cycle with MemAddr = index*4 and MemData = assembled word.
REQ-021 In WRITE, index SHALL increment; if new index equals latched count go to CHECK (macro on) or DONE, else back to RECV.
REQ-022 ByteValid stalls SHALL add cycles with no state change; minimum throughput 5 cycles/word.
REQ-023 In DONE: CpuRun=1, Busy=0; Busy=1 in RECV, WRITE, CHECK.
REQ-024 MemWe SHALL never assert outside WRITE; MemAddr/MemData hold last values otherwise.

Reset
REQ-025 Reset low SHALL force IDLE immediately; all outputs 0, counters and word register 0, regardless of state.
REQ-026 Reset mid-load SHALL abort the load; no further MemWe until a new Start.

Configuration
REQ-027 INS_LOADER_CKSUM_EN defined: after the last word, CHECK accepts one extra byte; it SHALL equal the XOR of all program bytes; match -> DONE, mismatch -> IDLE with Err=1, CpuRun=0.
REQ-028 INS_LOADER_CKSUM_EN undefined: CHECK state and checksum logic absent; last WRITE goes to DONE; Err tied 0.

Structure
REQ-029 FSM state encoding and the endianness byte-lane constant SHALL live in the shared CPU definitions package alongside the existing control-signal constants.
REQ-030 One sub-module, byte_packer (byte counter plus 32-bit shift assembly), SHALL be used; FSM and address counter stay in ins_loader.

Verification
REQ-031 WordCount=2, bytes 20 01 00 05 / 00 00 00 00 with ByteValid always high -> MemWe at addr 0 data 32'h20010005, then addr 4 data 0; CpuRun=1 at cycle 11 after Start.
REQ-032 WordCount=0, Start -> no MemWe, DONE/CpuRun=1 next cycle (macro off).
REQ-033 ByteValid low for 3 cycles between bytes 2 and 3 -> identical write data, write delayed exactly 3 cycles.
REQ-034 Reset pulsed low after 6 bytes of a 3-word load -> outputs 0 immediately; new Start reloads from addr 0.
REQ-035 Macro on, 1 word 01 02 03 04, checksum 8'h04 -> DONE; checksum 8'h05 -> Err=1, CpuRun=0.
REQ-036 Start asserted during RECV -> ignored, index and latched count unchanged.
